// File: rtl/ks_audio_out.sv
// ks_audio_out: output stage for the Karplus-Strong voice. Applies a saturating
// gain to each captured sample, converts it to offset binary, double-buffers it
// against the output period and drives a 1-bit PWM or sigma-delta stream.
module ks_audio_out #(
  parameter int DATA_WIDTH = 8,
  parameter int GAIN_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] sample_i,
  input  logic                  sample_valid_i,
  input  logic [GAIN_WIDTH-1:0] gain_i,
  input  logic                  mode_sd_i,
  input  logic                  clear_flags_i,
  output logic                  pwm_o,
  output logic                  period_start_o,
  output logic                  overrun_o,
  output logic                  underrun_o
);

  localparam int PROD_W = DATA_WIDTH + GAIN_WIDTH + 1;
  localparam logic [DATA_WIDTH-1:0] MIDSCALE = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] CNT_LAST = '1;
  localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'((2 ** (DATA_WIDTH-1)) - 1);
  localparam logic signed [PROD_W-1:0] SAT_MIN = PROD_W'(-(2 ** (DATA_WIDTH-1)));

  // Clamp the wide scaled product into the signed sample range.
  function automatic logic signed [DATA_WIDTH-1:0] sat_clamp(
    input logic signed [PROD_W-1:0] v
  );
    logic signed [DATA_WIDTH-1:0] r;
    if (v > SAT_MAX) begin
      r = SAT_MAX[DATA_WIDTH-1:0];
    end else if (v < SAT_MIN) begin
      r = SAT_MIN[DATA_WIDTH-1:0];
    end else begin
      r = v[DATA_WIDTH-1:0];
    end
    return r;
  endfunction

  logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] pending_q, pending_d;
  logic                  pending_full_q, pending_full_d;
  logic [DATA_WIDTH-1:0] active_q, active_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic                  mode_q, mode_d;
  logic                  pwm_q, pwm_d;
  logic                  period_start_q, period_start_d;
  logic                  overrun_q, overrun_d;
  logic                  underrun_q, underrun_d;

  logic signed [DATA_WIDTH-1:0] sample_s;
  logic signed [PROD_W-1:0]     samp_ext;
  logic signed [PROD_W-1:0]     gain_ext;
  logic signed [PROD_W-1:0]     prod;
  logic signed [PROD_W-1:0]     scaled;
  logic signed [DATA_WIDTH-1:0] clamped;
  logic [DATA_WIDTH-1:0]        duty;
  logic                         wrap;
  logic                         sd_carry;
  logic [DATA_WIDTH-1:0]        sd_sum;

  // Gain path: widen so the product never wraps, floor-scale by unity, clamp, offset-binary.
  always_comb begin
    sample_s = sample_i;
    samp_ext = PROD_W'(sample_s);
    gain_ext = $signed({{(PROD_W-GAIN_WIDTH){1'b0}}, gain_i});
    prod     = samp_ext * gain_ext;
    scaled   = prod >>> (GAIN_WIDTH - 1);
    clamped  = sat_clamp(scaled);
    duty     = {~clamped[DATA_WIDTH-1], clamped[DATA_WIDTH-2:0]};
  end

  // Next-state: period counter, double buffer, sticky flags and 1-bit modulator.
  always_comb begin
    wrap           = (cnt_q == CNT_LAST);
    cnt_d          = cnt_q + DATA_WIDTH'(1);
    active_d       = active_q;
    mode_d         = mode_q;
    pending_d      = pending_q;
    pending_full_d = pending_full_q;
    period_start_d = wrap;

    // At the wrap the buffered value (fresh or held) becomes the active duty.
    if (wrap) begin
      active_d       = pending_q;
      mode_d         = mode_sd_i;
      pending_full_d = 1'b0;
    end
    if (sample_valid_i) begin
      pending_d      = duty;
      pending_full_d = 1'b1;
    end

    overrun_d  = (sample_valid_i && pending_full_q && !wrap) || (overrun_q && !clear_flags_i);
    underrun_d = (wrap && !pending_full_q) || (underrun_q && !clear_flags_i);

    {sd_carry, sd_sum} = {1'b0, acc_q} + {1'b0, active_q};
    if (mode_q) begin
      acc_d = sd_sum;
      pwm_d = sd_carry;
    end else begin
      acc_d = acc_q;
      pwm_d = (cnt_q < active_q);
    end
  end

  // State registers with synchronous active-low reset to midscale silence.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      pending_q      <= MIDSCALE;
      pending_full_q <= 1'b0;
      active_q       <= MIDSCALE;
      acc_q          <= '0;
      mode_q         <= 1'b0;
      pwm_q          <= 1'b0;
      period_start_q <= 1'b0;
      overrun_q      <= 1'b0;
      underrun_q     <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
      active_q       <= active_d;
      acc_q          <= acc_d;
      mode_q         <= mode_d;
      pwm_q          <= pwm_d;
      period_start_q <= period_start_d;
      overrun_q      <= overrun_d;
      underrun_q     <= underrun_d;
    end
  end

  assign pwm_o          = pwm_q;
  assign period_start_o = period_start_q;
  assign overrun_o      = overrun_q;
  assign underrun_o     = underrun_q;

endmodule

// File: tb/tb_ks_audio_out.sv
// Bench for ks_audio_out: directed test-plan scenarios plus a randomized run,
// all checked cycle by cycle against an integer-arithmetic reference model.
module tb_ks_audio_out;

  logic       clk_i = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] sample_i = '0;
  logic       sample_valid_i = 1'b0;
  logic [3:0] gain_i = '0;
  logic       mode_sd_i = 1'b0;
  logic       clear_flags_i = 1'b0;
  logic       pwm_o, period_start_o, overrun_o, underrun_o;

  ks_audio_out #(.DATA_WIDTH(8), .GAIN_WIDTH(4)) dut (
    .clk_i          (clk_i),
    .rst_n          (rst_n),
    .sample_i       (sample_i),
    .sample_valid_i (sample_valid_i),
    .gain_i         (gain_i),
    .mode_sd_i      (mode_sd_i),
    .clear_flags_i  (clear_flags_i),
    .pwm_o          (pwm_o),
    .period_start_o (period_start_o),
    .overrun_o      (overrun_o),
    .underrun_o     (underrun_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state, plain integers.
  int m_cnt = 0, m_pend = 128, m_full = 0, m_act = 128, m_acc = 0, m_mode = 0;
  int m_pwm = 0, m_ps = 0, m_ov = 0, m_un = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Duty from sample and gain: signed product, floor divide by unity (8), clamp, +128.
  function automatic int duty_of(input logic [7:0] s, input logic [3:0] g);
    int sv, p, q;
    sv = s[7] ? int'(s) - 256 : int'(s);
    p  = sv * int'(g);
    if (p >= 0) q = p / 8;
    else        q = -((-p + 7) / 8);
    if (q > 127)  q = 127;
    if (q < -128) q = -128;
    return q + 128;
  endfunction

  task automatic model_edge();
    int wrap, sum, ovs, uns;
    if (!rst_n) begin
      m_cnt = 0; m_pend = 128; m_full = 0; m_act = 128; m_acc = 0; m_mode = 0;
      m_pwm = 0; m_ps = 0; m_ov = 0; m_un = 0;
      return;
    end
    wrap = (m_cnt == 255);
    if (m_mode != 0) begin
      sum   = m_acc + m_act;
      m_pwm = (sum >= 256);
      m_acc = sum % 256;
    end else begin
      m_pwm = (m_cnt < m_act);
    end
    ovs  = (sample_valid_i && m_full != 0 && !wrap);
    uns  = (wrap && m_full == 0);
    m_ov = ovs || (m_ov != 0 && !clear_flags_i);
    m_un = uns || (m_un != 0 && !clear_flags_i);
    m_ps = wrap;
    if (wrap) begin
      m_act  = m_pend;
      m_mode = mode_sd_i;
    end
    if (sample_valid_i) begin
      m_pend = duty_of(sample_i, gain_i);
      m_full = 1;
    end else if (wrap) begin
      m_full = 0;
    end
    m_cnt = (m_cnt + 1) % 256;
  endtask

  task automatic step();
    @(posedge clk_i);
    model_edge();
    #1;
    chk("pwm", pwm_o, m_pwm);
    chk("period_start", period_start_o, m_ps);
    chk("overrun", overrun_o, m_ov);
    chk("underrun", underrun_o, m_un);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic capture(input logic [7:0] s, input logic [3:0] g);
    sample_i = s; gain_i = g; sample_valid_i = 1'b1;
    step();
    sample_valid_i = 1'b0;
  endtask

  task automatic clear_flags();
    clear_flags_i = 1'b1;
    step();
    clear_flags_i = 1'b0;
  endtask

  task automatic wait_ps();
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (!period_start_o && k < 300);
    chk("period_start_seen", period_start_o, 1);
  endtask

  task automatic period_highs(output int h);
    h = 0;
    repeat (256) begin
      step();
      h += int'(pwm_o);
    end
  endtask

  task automatic first_ps_latency(input string tag);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (!period_start_o && k < 300);
    chk(tag, k, 256);
  endtask

  initial begin
    int h, s;

    // Reset held for three cycles
    rst_n = 1'b0;
    repeat (3) begin
      step();
      chk("rst_pwm", pwm_o, 0);
      chk("rst_ps", period_start_o, 0);
      chk("rst_ovr", overrun_o, 0);
      chk("rst_udr", underrun_o, 0);
    end
    rst_n = 1'b1;
    first_ps_latency("first_ps_latency");
    chk("udr_after_first_wrap", underrun_o, 1);
    period_highs(h);
    chk("silence_highs", h, 128);

    // Unity gain
    clear_flags();
    run(100);
    capture(8'h40, 4'd8);
    wait_ps();
    period_highs(h);
    chk("unity_highs", h, 192);
    chk("unity_no_ovr", overrun_o, 0);

    // Saturation both ways
    run(50);
    capture(8'h7F, 4'd15);
    wait_ps();
    period_highs(h);
    chk("sat_pos_highs", h, 255);
    run(50);
    capture(8'h80, 4'd15);
    wait_ps();
    period_highs(h);
    chk("sat_neg_highs", h, 0);

    // Overrun, last sample wins
    clear_flags();
    run(20);
    capture(8'h10, 4'd8);
    run(20);
    capture(8'h20, 4'd8);
    chk("ovr_set", overrun_o, 1);
    wait_ps();
    period_highs(h);
    chk("last_wins_highs", h, 160);
    clear_flags();
    chk("ovr_cleared", overrun_o, 0);

    // Capture exactly on the wrap edge
    wait_ps();
    run(10);
    capture(8'h40, 4'd8);
    run(244);
    capture(8'h00, 4'd8);
    chk("wrap_cap_ps", period_start_o, 1);
    chk("wrap_cap_no_ovr", overrun_o, 0);
    period_highs(h);
    chk("wrap_cap_cur_highs", h, 192);
    period_highs(h);
    chk("wrap_cap_next_highs", h, 128);
    chk("wrap_cap_no_ovr2", overrun_o, 0);

    // Sigma-delta at duty 0x40
    mode_sd_i = 1'b1;
    run(30);
    capture(8'hC0, 4'd8);
    wait_ps();
    period_highs(h);
    chk("sd_highs", h, 64);
    repeat (64) begin
      s = 0;
      repeat (4) begin
        step();
        s += int'(pwm_o);
      end
      chk("sd_one_in_four", s, 1);
    end

    // Reset mid-period
    run(50);
    rst_n = 1'b0;
    step();
    chk("midrst_pwm", pwm_o, 0);
    chk("midrst_ps", period_start_o, 0);
    chk("midrst_ovr", overrun_o, 0);
    chk("midrst_udr", underrun_o, 0);
    rst_n = 1'b1;
    mode_sd_i = 1'b0;
    first_ps_latency("midrst_ps_latency");

    // Randomized traffic against the model
    repeat (4000) begin
      sample_valid_i = ($urandom_range(0, 99) < 2);
      sample_i       = 8'($urandom);
      gain_i         = 4'($urandom);
      clear_flags_i  = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 599) == 0) mode_sd_i = ~mode_sd_i;
      rst_n          = ($urandom_range(0, 2999) != 0);
      step();
    end
    sample_valid_i = 1'b0;
    clear_flags_i  = 1'b0;
    rst_n          = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ks_audio_out.md
Name: ks_audio_out

Overview:
- Output stage directly downstream of the Karplus-Strong string voice.
- Consumes the voice's signed 8-bit sample stream, applies a per-sample gain with saturation, and converts to offset-binary.
- Double-buffers the result against the output period and drives a 1-bit audio output in PWM or first-order sigma-delta mode.
- Emits a period-start strobe so upstream logic can pace sample production.

Parameters:
- DATA_WIDTH, 8: sample width and PWM counter width; one PWM period is 2^DATA_WIDTH clocks.
- GAIN_WIDTH, 4: gain input width; unity gain = 2^(GAIN_WIDTH-1).

Ports:
- clk_i  input  1  clock
- rst_n  input  1  synchronous, active-low reset
- sample_i  input  DATA_WIDTH  signed two's-complement sample from the string voice
- sample_valid_i  input  1  capture strobe for sample_i; any cycle, no backpressure
- gain_i  input  GAIN_WIDTH  unsigned gain; applied at capture
- mode_sd_i  input  1  0 = PWM, 1 = sigma-delta; sampled at period wrap
- clear_flags_i  input  1  clears the sticky flags
- pwm_o  output  1  registered 1-bit audio output
- period_start_o  output  1  one-cycle pulse at each period wrap
- overrun_o  output  1  sticky: a pending sample was overwritten before it was used
- underrun_o  output  1  sticky: a period wrap occurred with no fresh pending sample

Behaviour:
- Reset values (rst_n=0 at clk edge): counter cnt=0, pending=active=0x80 (midscale silence), pending_full=0, acc=0, mode_q=0, pwm_o=0, period_start_o=0, overrun_o=0, underrun_o=0. Reset mid-period aborts immediately; the first period after reset starts at cnt=0.
- Capture, on the cycle sample_valid_i=1:
  - prod = signed(sample_i) * unsigned({1'b0,gain_i}), DATA_WIDTH+GAIN_WIDTH+1 bits signed.
  - scaled = prod >>> (GAIN_WIDTH-1), arithmetic shift, truncation toward -inf.
  - Clamp scaled to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - duty = clamped with its MSB inverted (offset binary).
  - pending <= duty; pending_full <= 1.
- Counter: cnt runs freely 0..2^DATA_WIDTH-1 and wraps to 0.
- Wrap edge, on the edge where cnt == 2^DATA_WIDTH-1:
  - cnt <= 0; active <= pending; mode_q <= mode_sd_i; period_start_o <= 1 (0 on all other edges).
  - If pending_full=0 at the wrap, active reloads the previous pending value (hold last sample) and underrun_o <= 1.
  - pending_full <= 0, unless a capture happens on the same edge.
- Simultaneous capture and wrap: active takes the old pending value; the new sample goes to pending with pending_full=1; no overrun.
- Overrun: capture while pending_full=1 and no wrap on the same edge. Then overrun_o <= 1 and the new sample replaces pending (last one wins).
- Sticky flags: clear_flags_i=1 clears both flags; if a set condition occurs on the same edge, set wins.
- PWM mode (mode_q=0): pwm_o <= (cnt < active), unsigned compare.
  - duty 0 gives a constant low.
  - duty 2^DATA_WIDTH-1 gives high for 2^DATA_WIDTH-1 of 2^DATA_WIDTH cycles.
- Sigma-delta mode (mode_q=1): each cycle {carry, acc} = acc + active, DATA_WIDTH+1 bits; acc <= the low DATA_WIDTH bits; pwm_o <= carry. acc keeps running across mode changes; it is never cleared except by reset.
- Latency:
  - pwm_o reflects cnt/acc state with 1 clock of register delay.
  - A sample captured at edge t lands in pending at t; it enters active at the next wrap edge and first affects pwm_o on the edge after that.
- Arithmetic: no wrap-around anywhere in the gain path; all overflow is handled by the clamp.

Test Plan:
- Reset check: hold rst_n=0 for 3 cycles, then release with no captures.
  - Required: pwm_o, period_start_o and both flags are 0 during reset.
  - First period_start_o pulse 256 cycles after release; underrun_o=1 after it; pwm_o high 128/256 cycles per period.
- Unity gain: sample_i=0x40, gain_i=8, one capture mid-period, PWM mode.
  - Required: duty 0xC0; the next full period shows exactly 192 high cycles; overrun_o=0.
- Saturation: sample_i=0x7F, gain_i=15 → duty 0xFF, 255 high cycles per period. sample_i=0x80, gain_i=15 → duty 0x00, pwm_o constant low.
- Overrun and last-wins: captures of 0x10, then 0x20, within one period.
  - Required: overrun_o=1; the next period uses duty 0xA0 (160 high).
  - clear_flags_i for 1 cycle returns overrun_o to 0.
- Capture on wrap: sample_valid_i asserted exactly on the cnt=255 edge with sample_i=0x00; the previous pending was 0x40.
  - Required: the current period uses 0xC0; the following period uses 0x80; no overrun.
- Sigma-delta: mode_sd_i=1, sample_i=0xC0 (duty 0x40), gain 8.
  - Required: after the wrap, pwm_o is high exactly 1 of every 4 cycles, 64 per 256.
  - Assert rst_n=0 mid-period: all state returns to reset values on that edge.
